// File: rtl/em_74191.sv
// em_74191 -- 74191 synchronous 4-bit up/down counter (74190 decade variant
// when BCD=1), cascadable through max_min / nrco.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset, clears count
//   nload        active-low synchronous parallel load (beats count enable)
//   ncten        active-low count enable
//   dnup         direction: 0 = up, 1 = down
//   parallel_in  load data
//   count        counter value (QD..QA = [3:0])
//   max_min      terminal count for the current direction (combinational)
//   nrco         active-low ripple clock: low in the clk-low phase while
//                max_min=1 and ncten=0; its rising edge matches the wrap edge
module em_74191 #(
  parameter int unsigned BCD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nload,
  input  logic       ncten,
  input  logic       dnup,
  input  logic [3:0] parallel_in,
  output logic [3:0] count,
  output logic       max_min,
  output logic       nrco
);

  localparam logic [3:0] TOP = (BCD != 0) ? 4'd9 : 4'd15;

  logic [3:0] count_next;

  // Decade mode: any value at or above 9 wraps to 0 going up; going down only
  // 0 wraps (to 9), so 10..15 simply decrement back into the valid range.
  always_comb begin
    count_next = count;
    if (!nload) begin
      count_next = parallel_in;
    end else if (!ncten) begin
      if (dnup) begin
        count_next = (count == 4'd0) ? TOP : count - 4'd1;
      end else begin
        count_next = (count >= TOP) ? 4'd0 : count + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

  always_comb begin
    max_min = dnup ? (count == 4'd0) : (count == TOP);
  end

  always_comb begin
    nrco = ~(max_min & ~ncten & ~clk);
  end

endmodule
